// File: rtl/tx_wqe_pkg.sv
// tx_wqe_pkg: shared WQE field layout, WQE type codes and segmenter FSM states
package tx_wqe_pkg;

    localparam int LEN_LSB   = 0;
    localparam int LEN_MSB   = 31;
    localparam int VADDR_LSB = 32;
    localparam int VADDR_MSB = 95;
    localparam int QPN_LSB   = 96;
    localparam int QPN_MSB   = 119;
    localparam int START_BIT = 120;

    localparam logic WQE_TYPE_LS = 1'b0;
    localparam logic WQE_TYPE_BS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEG  = 2'd2,
        ST_WB   = 2'd3
    } seg_state_e;

endpackage

// File: rtl/wqe_segmenter.sv
// wqe_segmenter: fetches WQEs from the group scheduler and cuts them into PMTU packet descriptors
module wqe_segmenter
    import tx_wqe_pkg::*;
#(
    parameter int WQE_WIDTH           = 512,
    parameter int PWQE_BUF_ADDR_WIDTH = 2,
    parameter int PMTU_LOG2           = 12,
    parameter int BS_QUANTUM          = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_wqe_cache_empty,
    output logic                           o_wqe_cache_rd,
    input  logic                           i_wqe_val,
    input  logic                           i_wqe_type,
    input  logic [PWQE_BUF_ADDR_WIDTH-1:0] i_wqe_addr,
    input  logic [WQE_WIDTH-1:0]           i_wqe,
    output logic                           o_pwqe_wb,
    output logic [PWQE_BUF_ADDR_WIDTH-1:0] o_pwqe_addr,
    output logic [WQE_WIDTH-1:0]           o_pwqe,
    output logic                           o_slot_release,
    output logic [PWQE_BUF_ADDR_WIDTH-1:0] o_slot_release_addr,
    output logic                           o_pkt_val,
    input  logic                           i_pkt_rdy,
    output logic [23:0]                    o_pkt_qpn,
    output logic [63:0]                    o_pkt_vaddr,
    output logic [PMTU_LOG2:0]             o_pkt_len,
    output logic                           o_pkt_first,
    output logic                           o_pkt_last
);

    localparam int          LW         = PMTU_LOG2 + 1;
    localparam int          QW         = $clog2(BS_QUANTUM + 1);
    localparam logic [31:0] PMTU_BYTES = 32'd1 << PMTU_LOG2;

    seg_state_e                     state_q, state_d;
    logic [WQE_WIDTH-1:0]           wqe_q, wqe_d;
    logic                           type_q, type_d;
    logic [PWQE_BUF_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [QW-1:0]                  quant_q, quant_d;
    logic                           rd_q, rd_d, wb_q, wb_d, rel_q, rel_d;
    logic                           pkt_val_q, pkt_val_d, pkt_first_q, pkt_first_d, pkt_last_q, pkt_last_d;
    logic [LW-1:0]                  pkt_len_q, pkt_len_d;
    logic [63:0]                    pkt_vaddr_q, pkt_vaddr_d;
    logic [23:0]                    pkt_qpn_q, pkt_qpn_d;
    logic [31:0]                    len_nx;
    logic                           in_seg;

    // Next state, WQE update on each accepted packet, and the descriptor for the following cycle
    always_comb begin
        state_d = state_q;
        wqe_d   = wqe_q;
        type_d  = type_q;
        addr_d  = addr_q;
        quant_d = quant_q;
        rd_d    = 1'b0;
        wb_d    = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!i_wqe_cache_empty) begin
                    rd_d    = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_wqe_val) begin
                    wqe_d   = i_wqe;
                    type_d  = i_wqe_type;
                    addr_d  = i_wqe_addr;
                    quant_d = '0;
                    state_d = ST_SEG;
                end
            end
            ST_SEG: begin
                if (pkt_val_q && i_pkt_rdy) begin
                    wqe_d[LEN_MSB:LEN_LSB]     = wqe_q[LEN_MSB:LEN_LSB] - 32'(pkt_len_q);
                    wqe_d[VADDR_MSB:VADDR_LSB] = wqe_q[VADDR_MSB:VADDR_LSB] + 64'(pkt_len_q);
                    wqe_d[START_BIT]           = 1'b0;
                    quant_d                    = quant_q + 1'b1;
                    if (pkt_last_q) begin
                        rel_d   = (type_q == WQE_TYPE_BS);
                        state_d = ST_IDLE;
                    end else if (type_q == WQE_TYPE_BS && quant_d == QW'(BS_QUANTUM)) begin
                        wb_d    = 1'b1;
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        in_seg      = (state_d == ST_SEG);
        len_nx      = wqe_d[LEN_MSB:LEN_LSB];
        pkt_val_d   = in_seg;
        pkt_len_d   = !in_seg ? '0 : (len_nx > PMTU_BYTES) ? PMTU_BYTES[LW-1:0] : len_nx[LW-1:0];
        pkt_last_d  = in_seg && (len_nx <= PMTU_BYTES);
        pkt_first_d = in_seg && wqe_d[START_BIT];
        pkt_vaddr_d = in_seg ? wqe_d[VADDR_MSB:VADDR_LSB] : '0;
        pkt_qpn_d   = in_seg ? wqe_d[QPN_MSB:QPN_LSB] : '0;
    end

    // State and registered outputs; reset drops any in-flight WQE without writeback or release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wqe_q       <= '0;
            type_q      <= 1'b0;
            addr_q      <= '0;
            quant_q     <= '0;
            rd_q        <= 1'b0;
            wb_q        <= 1'b0;
            rel_q       <= 1'b0;
            pkt_val_q   <= 1'b0;
            pkt_len_q   <= '0;
            pkt_first_q <= 1'b0;
            pkt_last_q  <= 1'b0;
            pkt_vaddr_q <= '0;
            pkt_qpn_q   <= '0;
        end else begin
            state_q     <= state_d;
            wqe_q       <= wqe_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            quant_q     <= quant_d;
            rd_q        <= rd_d;
            wb_q        <= wb_d;
            rel_q       <= rel_d;
            pkt_val_q   <= pkt_val_d;
            pkt_len_q   <= pkt_len_d;
            pkt_first_q <= pkt_first_d;
            pkt_last_q  <= pkt_last_d;
            pkt_vaddr_q <= pkt_vaddr_d;
            pkt_qpn_q   <= pkt_qpn_d;
        end
    end

    assign o_wqe_cache_rd      = rd_q;
    assign o_pwqe_wb           = wb_q;
    assign o_pwqe_addr         = addr_q;
    assign o_pwqe              = wqe_q;
    assign o_slot_release      = rel_q;
    assign o_slot_release_addr = addr_q;
    assign o_pkt_val           = pkt_val_q;
    assign o_pkt_qpn           = pkt_qpn_q;
    assign o_pkt_vaddr         = pkt_vaddr_q;
    assign o_pkt_len           = pkt_len_q;
    assign o_pkt_first         = pkt_first_q;
    assign o_pkt_last          = pkt_last_q;

endmodule

// File: tb/tb_wqe_segmenter.sv
// tb_wqe_segmenter: randomized scenarios checked against a packet-list model of WQE segmentation
module tb_wqe_segmenter;
    import tx_wqe_pkg::*;

    logic         clk, rst_n;
    logic         i_wqe_cache_empty, o_wqe_cache_rd;
    logic         i_wqe_val, i_wqe_type;
    logic [1:0]   i_wqe_addr;
    logic [511:0] i_wqe;
    logic         o_pwqe_wb;
    logic [1:0]   o_pwqe_addr;
    logic [511:0] o_pwqe;
    logic         o_slot_release;
    logic [1:0]   o_slot_release_addr;
    logic         o_pkt_val, i_pkt_rdy;
    logic [23:0]  o_pkt_qpn;
    logic [63:0]  o_pkt_vaddr;
    logic [12:0]  o_pkt_len;
    logic         o_pkt_first, o_pkt_last;

    wqe_segmenter #(.WQE_WIDTH(512), .PWQE_BUF_ADDR_WIDTH(2), .PMTU_LOG2(12), .BS_QUANTUM(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_wqe_cache_empty(i_wqe_cache_empty), .o_wqe_cache_rd(o_wqe_cache_rd),
        .i_wqe_val(i_wqe_val), .i_wqe_type(i_wqe_type), .i_wqe_addr(i_wqe_addr), .i_wqe(i_wqe),
        .o_pwqe_wb(o_pwqe_wb), .o_pwqe_addr(o_pwqe_addr), .o_pwqe(o_pwqe),
        .o_slot_release(o_slot_release), .o_slot_release_addr(o_slot_release_addr),
        .o_pkt_val(o_pkt_val), .i_pkt_rdy(i_pkt_rdy), .o_pkt_qpn(o_pkt_qpn),
        .o_pkt_vaddr(o_pkt_vaddr), .o_pkt_len(o_pkt_len),
        .o_pkt_first(o_pkt_first), .o_pkt_last(o_pkt_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] qpn;
        logic [63:0] vaddr;
        logic [12:0] len;
        logic        first;
        logic        last;
    } pkt_t;

    pkt_t         cap[$], exp_q[$];
    int           checks, passes;
    int           wb_cnt, rel_cnt, stab_err, rd_cnt, both_cnt, timeout_cnt;
    logic [1:0]   wb_addr, rel_addr;
    logic [511:0] wb_data, exp_pwqe;
    bit           exp_wb, exp_rel;

    wire [669:0] all_out = {o_wqe_cache_rd, o_pwqe_wb, o_pwqe_addr, o_pwqe, o_slot_release,
                            o_slot_release_addr, o_pkt_val, o_pkt_qpn, o_pkt_vaddr, o_pkt_len,
                            o_pkt_first, o_pkt_last};

    function automatic logic [511:0] rnd512();
        logic [511:0] w;
        for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [511:0] mk(logic [31:0] len, logic [63:0] va, logic [23:0] qpn, logic st);
        logic [511:0] w;
        w = rnd512();
        w[31:0]   = len;
        w[95:32]  = va;
        w[119:96] = qpn;
        w[120]    = st;
        return w;
    endfunction

    // Reference: walk the message in PMTU steps, stopping at the last packet or at the BS quantum
    task automatic model(input logic [511:0] w, input logic t);
        logic [31:0] rem;
        logic [63:0] va;
        logic [12:0] l;
        logic        st, last;
        pkt_t        p;
        int          n;
        exp_q.delete();
        rem = w[31:0]; va = w[95:32]; st = w[120]; n = 0; last = 0;
        forever begin
            l    = (rem > 32'd4096) ? 13'd4096 : rem[12:0];
            last = (rem <= 32'd4096);
            p.qpn = w[119:96]; p.vaddr = va; p.len = l; p.first = st; p.last = last;
            exp_q.push_back(p);
            va = va + 64'(l); rem = rem - 32'(l); st = 0; n++;
            if (last || (t == WQE_TYPE_BS && n == 4)) break;
        end
        exp_rel  = last && (t == WQE_TYPE_BS);
        exp_wb   = !last;
        exp_pwqe = {w[511:121], 1'b0, w[119:96], va, rem};
    endtask

    // Scheduler and sink emulation: one fetch, then capture everything the DUT emits
    task automatic run_wqe(input logic [511:0] w, input logic t, input logic [1:0] a, input int dly, input int mode);
        pkt_t cur, prev;
        bit   hold, started, tog, rdy;
        int   idle, cyc;
        cap.delete();
        wb_cnt = 0; rel_cnt = 0; stab_err = 0; rd_cnt = 0; both_cnt = 0; timeout_cnt = 0;
        hold = 0; started = 0; tog = 0; idle = 0; prev = '0;
        i_wqe_cache_empty = 1'b0;
        cyc = 0;
        while (!o_wqe_cache_rd && cyc < 20) begin @(negedge clk); cyc++; end
        if (o_wqe_cache_rd) rd_cnt = 1; else timeout_cnt++;
        i_wqe_cache_empty = 1'b1;
        for (int k = 0; k < dly; k++) begin @(negedge clk); if (o_wqe_cache_rd) rd_cnt++; end
        i_wqe = w; i_wqe_type = t; i_wqe_addr = a; i_wqe_val = 1'b1;
        @(negedge clk);
        i_wqe_val = 1'b0; i_wqe = rnd512(); i_wqe_type = ~t; i_wqe_addr = ~a;
        for (cyc = 0; cyc < 600 && idle < 4; cyc++) begin
            cur.qpn = o_pkt_qpn; cur.vaddr = o_pkt_vaddr; cur.len = o_pkt_len;
            cur.first = o_pkt_first; cur.last = o_pkt_last;
            if (o_wqe_cache_rd) rd_cnt++;
            if (o_pwqe_wb) begin wb_cnt++; wb_addr = o_pwqe_addr; wb_data = o_pwqe; end
            if (o_slot_release) begin rel_cnt++; rel_addr = o_slot_release_addr; end
            if (o_pwqe_wb && o_slot_release) both_cnt++;
            if (hold && (!o_pkt_val || cur !== prev)) stab_err++;
            tog = !tog;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            i_pkt_rdy = rdy;
            i_wqe_val = (cyc == 1);
            if (o_pkt_val && rdy) cap.push_back(cur);
            if (o_pkt_val) started = 1;
            idle = (started && !o_pkt_val) ? idle + 1 : 0;
            hold = o_pkt_val && !rdy;
            prev = cur;
            @(negedge clk);
        end
        if (idle < 4) timeout_cnt++;
        i_pkt_rdy = 1'b0; i_wqe_val = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (all_out !== '0) $display("FAIL reset_outputs got %h required 0", all_out); else passes++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (all_out !== '0) $display("FAIL post_reset_idle got %h required 0", all_out); else passes++;
    endtask

    task automatic test_ls();
        logic [511:0] w;
        logic [63:0]  va_e[3] = '{64'h1000, 64'h2000, 64'h3000};
        logic [12:0]  ln_e[3] = '{13'd4096, 13'd4096, 13'd1808};
        w = mk(32'd10000, 64'h1000, 24'h00abcd, 1'b1);
        run_wqe(w, WQE_TYPE_LS, 2'd1, 1, 0);
        model(w, WQE_TYPE_LS);
        checks++; if (cap.size() !== 3) $display("FAIL ls_count got %0d required 3", cap.size()); else passes++;
        for (int i = 0; i < cap.size() && i < 3; i++) begin
            checks++;
            if (cap[i].vaddr !== va_e[i] || cap[i].len !== ln_e[i] || cap[i].first !== (i == 0) || cap[i].last !== (i == 2))
                $display("FAIL ls_pkt%0d got %h required va=%h len=%0d", i, cap[i], va_e[i], ln_e[i]);
            else passes++;
            checks++; if (cap[i] !== exp_q[i]) $display("FAIL ls_model%0d got %h required %h", i, cap[i], exp_q[i]); else passes++;
        end
        checks++; if (wb_cnt + rel_cnt !== 0) $display("FAIL ls_no_wb_rel got wb=%0d rel=%0d required 0", wb_cnt, rel_cnt); else passes++;
        checks++; if (timeout_cnt !== 0) $display("FAIL ls_timeout got %0d required 0", timeout_cnt); else passes++;
    endtask

    task automatic test_bs();
        logic [511:0] w, pw;
        w = mk(32'd20000, 64'h0000_0001_0000_0000, 24'h5a5a5a, 1'b1);
        run_wqe(w, WQE_TYPE_BS, 2'd2, 1, 0);
        model(w, WQE_TYPE_BS);
        pw = wb_data;
        checks++; if (cap.size() !== 4) $display("FAIL bs_count got %0d required 4", cap.size()); else passes++;
        for (int i = 0; i < cap.size() && i < 4; i++) begin
            checks++; if (cap[i] !== exp_q[i] || cap[i].len !== 13'd4096) $display("FAIL bs_pkt%0d got %h required %h", i, cap[i], exp_q[i]); else passes++;
        end
        checks++; if (wb_cnt !== 1 || wb_addr !== 2'd2) $display("FAIL bs_wb got cnt=%0d addr=%0d required 1/2", wb_cnt, wb_addr); else passes++;
        checks++; if (pw[31:0] !== 32'd3616 || pw[95:32] !== 64'h0000_0001_0000_4000 || pw[120] !== 1'b0)
            $display("FAIL bs_pwqe_fields got len=%0d va=%h st=%b required 3616/100004000/0", pw[31:0], pw[95:32], pw[120]); else passes++;
        checks++; if (pw !== exp_pwqe) $display("FAIL bs_pwqe got %h required %h", pw, exp_pwqe); else passes++;
        checks++; if (pw[511:121] !== w[511:121]) $display("FAIL bs_opaque got %h required %h", pw[511:121], w[511:121]); else passes++;
        checks++; if (rel_cnt !== 0) $display("FAIL bs_no_release got %0d required 0", rel_cnt); else passes++;
        run_wqe(pw, WQE_TYPE_BS, 2'd2, 1, 0);
        checks++; if (cap.size() !== 1) $display("FAIL refetch_count got %0d required 1", cap.size()); else passes++;
        checks++; if (cap.size() > 0 && (cap[0].len !== 13'd3616 || cap[0].first !== 1'b0 || cap[0].last !== 1'b1 || cap[0].vaddr !== 64'h0000_0001_0000_4000))
            $display("FAIL refetch_pkt got %h required len=3616 first=0 last=1", cap[0]); else passes++;
        checks++; if (rel_cnt !== 1 || rel_addr !== 2'd2 || wb_cnt !== 0) $display("FAIL refetch_release got rel=%0d addr=%0d wb=%0d required 1/2/0", rel_cnt, rel_addr, wb_cnt); else passes++;
    endtask

    task automatic test_len_zero();
        run_wqe(mk(32'd0, 64'hdead_0000, 24'h000777, 1'b1), WQE_TYPE_LS, 2'd0, 1, 0);
        checks++; if (cap.size() !== 1) $display("FAIL len0_count got %0d required 1", cap.size()); else passes++;
        checks++; if (cap.size() > 0 && (cap[0].len !== 13'd0 || cap[0].first !== 1'b1 || cap[0].last !== 1'b1))
            $display("FAIL len0_pkt got %h required len=0 first=1 last=1", cap[0]); else passes++;
    endtask

    task automatic test_rdy_toggle();
        logic [511:0] w;
        w = mk(32'd16389, 64'hffff_ffff_ffff_e000, 24'h123456, 1'b1);
        run_wqe(w, WQE_TYPE_LS, 2'd3, 1, 1);
        model(w, WQE_TYPE_LS);
        checks++; if (stab_err !== 0) $display("FAIL toggle_stable got %0d changes required 0", stab_err); else passes++;
        checks++; if (cap.size() !== exp_q.size()) $display("FAIL toggle_count got %0d required %0d", cap.size(), exp_q.size()); else passes++;
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
            checks++; if (cap[i] !== exp_q[i]) $display("FAIL toggle_pkt%0d got %h required %h", i, cap[i], exp_q[i]); else passes++;
        end
    endtask

    task automatic test_delay_and_empty();
        int rds;
        logic [511:0] w;
        rds = 0;
        i_wqe_cache_empty = 1'b1;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (o_wqe_cache_rd) rds++; end
        checks++; if (rds !== 0) $display("FAIL empty_no_rd got %0d required 0", rds); else passes++;
        w = mk(32'd5000, 64'h40, 24'h000001, 1'b1);
        run_wqe(w, WQE_TYPE_BS, 2'd1, 5, 0);
        model(w, WQE_TYPE_BS);
        checks++; if (rd_cnt !== 1) $display("FAIL delay_one_rd got %0d required 1", rd_cnt); else passes++;
        checks++; if (cap.size() !== 2 || cap[0] !== exp_q[0] || cap[1] !== exp_q[1]) $display("FAIL delay_pkts got %0d pkts required %0d", cap.size(), exp_q.size()); else passes++;
        checks++; if (rel_cnt !== 1 || rel_addr !== 2'd1) $display("FAIL delay_release got %0d addr %0d required 1/1", rel_cnt, rel_addr); else passes++;
    endtask

    task automatic test_random();
        logic [511:0] w;
        logic [63:0]  va;
        logic [31:0]  len;
        logic [1:0]   a;
        logic         t;
        for (int n = 0; n < 24; n++) begin
            t   = 1'($urandom_range(0, 1));
            a   = 2'($urandom_range(0, 3));
            len = (t && $urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 40000));
            va  = $urandom_range(0, 1) ? {$urandom, $urandom} : {32'hffff_ffff, 32'hffff_0000 | 32'($urandom_range(0, 65535))};
            w   = mk(len, va, 24'($urandom), 1'($urandom_range(0, 1)));
            run_wqe(w, t, a, $urandom_range(1, 6), $urandom_range(0, 2));
            model(w, t);
            checks++; if (cap.size() !== exp_q.size()) $display("FAIL rnd%0d_count got %0d required %0d", n, cap.size(), exp_q.size()); else passes++;
            for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
                checks++; if (cap[i] !== exp_q[i]) $display("FAIL rnd%0d_pkt%0d got %h required %h", n, i, cap[i], exp_q[i]); else passes++;
            end
            checks++; if (wb_cnt !== int'(exp_wb) || (exp_wb && (wb_data !== exp_pwqe || wb_addr !== a)))
                $display("FAIL rnd%0d_wb got cnt=%0d addr=%0d required cnt=%0d addr=%0d", n, wb_cnt, wb_addr, exp_wb, a); else passes++;
            checks++; if (rel_cnt !== int'(exp_rel) || (exp_rel && rel_addr !== a))
                $display("FAIL rnd%0d_rel got cnt=%0d addr=%0d required cnt=%0d addr=%0d", n, rel_cnt, rel_addr, exp_rel, a); else passes++;
            checks++; if (stab_err + both_cnt + timeout_cnt !== 0 || rd_cnt !== 1)
                $display("FAIL rnd%0d_proto got stab=%0d both=%0d timeout=%0d rd=%0d required 0/0/0/1", n, stab_err, both_cnt, timeout_cnt, rd_cnt); else passes++;
        end
    endtask

    task automatic test_reset_mid_seg();
        int cyc, evts;
        i_wqe_cache_empty = 1'b0;
        cyc = 0;
        while (!o_wqe_cache_rd && cyc < 20) begin @(negedge clk); cyc++; end
        i_wqe_cache_empty = 1'b1;
        @(negedge clk);
        i_wqe = mk(32'd30000, 64'h8000, 24'h0000aa, 1'b1); i_wqe_type = WQE_TYPE_BS; i_wqe_addr = 2'd3; i_wqe_val = 1'b1;
        @(negedge clk);
        i_wqe_val = 1'b0; i_pkt_rdy = 1'b1;
        @(negedge clk);
        checks++; if (o_pkt_val !== 1'b1) $display("FAIL midseg_active got %b required 1", o_pkt_val); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (all_out !== '0) $display("FAIL midseg_reset_outputs got %h required 0", all_out); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        evts = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (o_pkt_val || o_pwqe_wb || o_slot_release || o_wqe_cache_rd) evts++;
        end
        checks++; if (evts !== 0) $display("FAIL midseg_quiet got %0d events required 0", evts); else passes++;
        i_pkt_rdy = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; passes = 0;
        rst_n = 1'b0; i_wqe_cache_empty = 1'b1; i_wqe_val = 1'b0; i_wqe_type = 1'b0;
        i_wqe_addr = '0; i_wqe = '0; i_pkt_rdy = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_ls();
        test_bs();
        test_len_zero();
        test_rdy_toggle();
        test_delay_and_empty();
        test_random();
        test_reset_mid_seg();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
